// File: rtl/traffic_light_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_pkg
// Purpose  : Shared phase type and lamp encoding for the intersection controller
// Revision : 1.0
// ============================================================================
package traffic_light_pkg;

    typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW} light_state_e;

    // Lamp triplet ordering is {red, yellow, green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    function automatic logic [2:0] lamp_code(input light_state_e s);
        case (s)
            GREEN:   return LAMP_GREEN;
            YELLOW:  return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : traffic_rr_pick
// Purpose  : Combinational round-robin / pre-emption approach selector
// Revision : 1.0
// ============================================================================
module traffic_rr_pick #(
    parameter int NUM_DIR = 4,
    parameter int DIR_W   = 2
) (
    input  logic [NUM_DIR-1:0] car_req,
    input  logic [DIR_W-1:0]   cur_dir,
    input  logic               emg_valid,
    input  logic [DIR_W-1:0]   emg_dir,
    output logic [DIR_W-1:0]   next_dir,
    output logic               other_req
);
    import traffic_light_pkg::*;

    int w_idx;

    always_comb begin
        w_idx     = 0;
        other_req = 1'b0;
        next_dir  = (int'(cur_dir) == NUM_DIR - 1) ? '0 : cur_dir + 1'b1;

        // Scan farthest-first so the nearest requester after cur_dir wins
        for (int i = NUM_DIR; i >= 1; i--) begin
            w_idx = int'(cur_dir) + i;
            if (w_idx >= NUM_DIR)
                w_idx = w_idx - NUM_DIR;
            if (car_req[w_idx])
                next_dir = DIR_W'(w_idx);
        end

        for (int i = 0; i < NUM_DIR; i++) begin
            if (car_req[i] && (i != int'(cur_dir)))
                other_req = 1'b1;
        end

        if (emg_valid)
            next_dir = emg_dir;
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl
// Purpose  : N-way timed intersection controller with emergency pre-emption
// Revision : 1.0
// ============================================================================
module traffic_light_ctrl #(
    parameter int NUM_DIR    = 4,
    parameter int CNT_W      = 16,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       tick,
    input  logic [NUM_DIR-1:0]         car_req,
    input  logic                       emergency,
    input  logic [$clog2(NUM_DIR)-1:0] emg_dir,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic                       phase_done
);
    import traffic_light_pkg::*;

    localparam int               DIR_W          = $clog2(NUM_DIR);
    localparam logic [CNT_W-1:0] c_green_load   = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] c_yellow_load  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] c_allred_load  = CNT_W'(ALLRED_CYC - 1);

    light_state_e       r_state, w_state_nx;
    logic [DIR_W-1:0]   r_cur_dir, w_dir_nx;
    logic [CNT_W-1:0]   r_timer, w_timer_nx;
    logic               r_emg_held, w_held_nx;
    logic [NUM_DIR-1:0] r_red, r_yellow, r_green;
    logic [NUM_DIR-1:0] w_red, w_yellow, w_green;
    logic [DIR_W-1:0]   r_active_dir;
    logic               r_phase_done;
    logic               w_emg_valid, w_expiry, w_other_req;
    logic [DIR_W-1:0]   w_next_dir;

    assign w_emg_valid = emergency && (int'(emg_dir) < NUM_DIR);
    assign w_expiry    = tick && (r_timer == '0);

    traffic_rr_pick #(
        .NUM_DIR (NUM_DIR),
        .DIR_W   (DIR_W)
    ) u_pick (
        .car_req   (car_req),
        .cur_dir   (r_cur_dir),
        .emg_valid (w_emg_valid),
        .emg_dir   (emg_dir),
        .next_dir  (w_next_dir),
        .other_req (w_other_req)
    );

    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_cur_dir;
        w_timer_nx = tick ? r_timer - 1'b1 : r_timer;
        w_held_nx  = r_emg_held;
        case (r_state)
            ALL_RED: begin
                if (w_expiry) begin
                    w_state_nx = GREEN;
                    w_dir_nx   = w_next_dir;
                    w_timer_nx = c_green_load;
                    w_held_nx  = 1'b0;
                end
            end
            GREEN: begin
                if (w_emg_valid && (r_cur_dir != emg_dir)) begin
                    w_state_nx = YELLOW;
                    w_timer_nx = c_yellow_load;
                    w_held_nx  = 1'b0;
                end else if (w_emg_valid) begin
                    w_timer_nx = r_timer;
                    w_held_nx  = 1'b1;
                end else if (r_emg_held) begin
                    // Pre-emption just released: grant a full fresh green
                    w_timer_nx = c_green_load;
                    w_held_nx  = 1'b0;
                end else if (w_expiry) begin
                    w_timer_nx = c_green_load;
                    if (w_other_req) begin
                        w_state_nx = YELLOW;
                        w_timer_nx = c_yellow_load;
                    end
                end
            end
            YELLOW: begin
                if (w_expiry) begin
                    w_state_nx = ALL_RED;
                    w_timer_nx = c_allred_load;
                end
            end
            default: begin
                w_state_nx = ALL_RED;
                w_timer_nx = c_allred_load;
                w_held_nx  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_red    = '1;
        w_yellow = '0;
        w_green  = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (i == int'(w_dir_nx))
                {w_red[i], w_yellow[i], w_green[i]} = lamp_code(w_state_nx);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state      <= ALL_RED;
            r_cur_dir    <= DIR_W'(NUM_DIR - 1);
            r_timer      <= c_allred_load;
            r_emg_held   <= 1'b0;
            r_red        <= '1;
            r_yellow     <= '0;
            r_green      <= '0;
            r_active_dir <= DIR_W'(NUM_DIR - 1);
            r_phase_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cur_dir    <= w_dir_nx;
            r_timer      <= w_timer_nx;
            r_emg_held   <= w_held_nx;
            r_red        <= w_red;
            r_yellow     <= w_yellow;
            r_green      <= w_green;
            r_active_dir <= w_dir_nx;
            r_phase_done <= (w_state_nx != r_state);
        end
    end

    assign red        = r_red;
    assign yellow     = r_yellow;
    assign green      = r_green;
    assign active_dir = r_active_dir;
    assign phase_done = r_phase_done;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_ctrl
// Purpose  : Directed vector bench for traffic_light_ctrl (4 approaches, 8/3/2)
// Revision : 1.0
// ============================================================================
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rstb;
    logic       tick;
    logic [3:0] car_req;
    logic       emergency;
    logic [1:0] emg_dir;
    logic [3:0] red, yellow, green;
    logic [1:0] active_dir;
    logic       phase_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .NUM_DIR    (4),
        .CNT_W      (16),
        .GREEN_CYC  (8),
        .YELLOW_CYC (3),
        .ALLRED_CYC (2)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .tick       (tick),
        .car_req    (car_req),
        .emergency  (emergency),
        .emg_dir    (emg_dir),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .active_dir (active_dir),
        .phase_done (phase_done)
    );

    typedef struct {
        string      name;
        logic [3:0] req;
        logic       emg;
        logic [1:0] edir;
        int         cyc;
        logic [3:0] r, y, g;
        logic [1:0] ad;
        logic       pd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(string nm, logic [3:0] req, logic emg, logic [1:0] edir, int cyc,
                                logic [3:0] r, logic [3:0] y, logic [3:0] g, logic [1:0] ad, logic pd);
        vec_t v;
        v.name = nm; v.req = req; v.emg = emg; v.edir = edir; v.cyc = cyc;
        v.r = r; v.y = y; v.g = g; v.ad = ad; v.pd = pd;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_lamps(input string nm, input logic [3:0] r, input logic [3:0] y,
                               input logic [3:0] g, input logic [1:0] ad, input logic pd);
        check({nm, ".red"},        32'(red),        32'(r));
        check({nm, ".yellow"},     32'(yellow),     32'(y));
        check({nm, ".green"},      32'(green),      32'(g));
        check({nm, ".active_dir"}, 32'(active_dir), 32'(ad));
        check({nm, ".phase_done"}, 32'(phase_done), 32'(pd));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int pd_edges[$];

    initial begin
        rstb = 1'b0; tick = 1'b1; car_req = '0; emergency = 1'b0; emg_dir = '0;

        // Edge counts below are relative to the first edge after reset release
        add("rst_ar",      4'b0000, 0, 0, 1, 4'b1111, 4'b0000, 4'b0000, 3, 0);
        add("first_green", 4'b0000, 0, 0, 1, 4'b1110, 4'b0000, 4'b0001, 0, 1);
        add("green_hold",  4'b0000, 0, 0, 1, 4'b1110, 4'b0000, 4'b0001, 0, 0);
        add("green_ext1",  4'b0000, 0, 0, 7, 4'b1110, 4'b0000, 4'b0001, 0, 0);
        add("green_ext2",  4'b0000, 0, 0, 8, 4'b1110, 4'b0000, 4'b0001, 0, 0);
        add("req02_green", 4'b0101, 0, 0, 7, 4'b1110, 4'b0000, 4'b0001, 0, 0);
        add("yellow_d0",   4'b0101, 0, 0, 1, 4'b1110, 4'b0001, 4'b0000, 0, 1);
        add("yellow_d0_e", 4'b0101, 0, 0, 2, 4'b1110, 4'b0001, 4'b0000, 0, 0);
        add("allred_d0",   4'b0101, 0, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 1);
        add("allred_d0_e", 4'b0101, 0, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        add("green_skip",  4'b0101, 0, 0, 1, 4'b1011, 4'b0000, 4'b0100, 2, 1);
        add("yellow_d2",   4'b0001, 0, 0, 8, 4'b1011, 4'b0100, 4'b0000, 2, 1);
        add("allred_d2",   4'b0000, 0, 0, 3, 4'b1111, 4'b0000, 4'b0000, 2, 1);
        add("green_fallbk",4'b0000, 0, 0, 2, 4'b0111, 4'b0000, 4'b1000, 3, 1);
        add("yellow_d3",   4'b0010, 0, 0, 8, 4'b0111, 4'b1000, 4'b0000, 3, 1);
        add("allred_d3",   4'b0010, 0, 0, 3, 4'b1111, 4'b0000, 4'b0000, 3, 1);
        add("green_wrap",  4'b0010, 0, 0, 2, 4'b1101, 4'b0000, 4'b0010, 1, 1);
        add("green_t5",    4'b0010, 0, 0, 2, 4'b1101, 4'b0000, 4'b0010, 1, 0);
        add("emg_yellow",  4'b0010, 1, 3, 1, 4'b1101, 4'b0010, 4'b0000, 1, 1);
        add("emg_allred",  4'b0010, 1, 3, 3, 4'b1111, 4'b0000, 4'b0000, 1, 1);
        add("emg_green",   4'b0010, 1, 3, 2, 4'b0111, 4'b0000, 4'b1000, 3, 1);
        add("emg_held",    4'b0010, 1, 3, 20, 4'b0111, 4'b0000, 4'b1000, 3, 0);
        add("emg_release", 4'b0011, 0, 0, 1, 4'b0111, 4'b0000, 4'b1000, 3, 0);
        add("post_emg_g",  4'b0011, 0, 0, 7, 4'b0111, 4'b0000, 4'b1000, 3, 0);
        add("post_emg_y",  4'b0011, 0, 0, 1, 4'b0111, 4'b1000, 4'b0000, 3, 1);

        #12;
        check_lamps("reset", 4'b1111, 4'b0000, 4'b0000, 3, 0);
        @(posedge clk); #1;
        rstb = 1'b1;

        foreach (vq[k]) begin
            car_req   = vq[k].req;
            emergency = vq[k].emg;
            emg_dir   = vq[k].edir;
            step(vq[k].cyc);
            check_lamps(vq[k].name, vq[k].r, vq[k].y, vq[k].g, vq[k].ad, vq[k].pd);
        end

        // Asynchronous reset in the middle of yellow
        car_req = '0; emergency = 1'b0;
        #2 rstb = 1'b0;
        #1 check_lamps("async_rst", 4'b1111, 4'b0000, 4'b0000, 3, 0);
        step(2);
        rstb = 1'b1;
        step(1); check_lamps("rst2_ar",     4'b1111, 4'b0000, 4'b0000, 3, 0);
        step(1); check_lamps("rst2_green",  4'b1110, 4'b0000, 4'b0001, 0, 1);
        step(7); check_lamps("rst2_green8", 4'b1110, 4'b0000, 4'b0001, 0, 0);
        car_req = 4'b0010;
        step(1); check_lamps("rst2_yellow", 4'b1110, 4'b0001, 4'b0000, 0, 1);

        // Tick every 4th cycle: phases stretch to 32/12/8 cycles
        rstb = 1'b0; car_req = 4'b0011;
        step(2);
        rstb = 1'b1;
        for (int e = 1; e <= 64; e++) begin
            tick = (e % 4 == 0);
            step(1);
            if (phase_done)
                pd_edges.push_back(e);
            if (e == 8)
                check_lamps("slow_green0", 4'b1110, 4'b0000, 4'b0001, 0, 1);
            if (e == 60)
                check_lamps("slow_green1", 4'b1101, 4'b0000, 4'b0010, 1, 1);
        end
        check("slow_pd_count", 32'(pd_edges.size()), 32'd4);
        if (pd_edges.size() == 4) begin
            check("slow_pd_green",  32'(pd_edges[0]), 32'd8);
            check("slow_pd_yellow", 32'(pd_edges[1]), 32'd40);
            check("slow_pd_allred", 32'(pd_edges[2]), 32'd52);
            check("slow_pd_green2", 32'(pd_edges[3]), 32'd60);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
